// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I execute datapath.
//   - opcode constants (inst[6:0])
//   - funct3 constants for branches, loads/stores and the integer ALU
//   - jmp_op encoding driven to the PC logic
//   - alu_sel_e: result selector for the write-back value
//   - ctrl_t: decoded control bundle from rv32i_decoder to the datapath
//   - alu_op_sel(): funct3 (+ inst[30]) to ALU operation mapping
package rv32i_pkg;

    localparam int XLEN_C = 32;

    // Opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // jmp_op encoding
    localparam logic [1:0] JMP_SEQ    = 2'd0;
    localparam logic [1:0] JMP_JUMP   = 2'd1;
    localparam logic [1:0] JMP_BRANCH = 2'd2;
    localparam logic [1:0] JMP_RSVD   = 2'd3;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_IMM,
        ALU_PC_IMM,
        ALU_PC_4
    } alu_sel_e;

    typedef struct packed {
        alu_sel_e   alu_sel;
        logic       src_b_imm;  // operand b is imm instead of rs2_data
        logic       reg_write;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jalr;
        logic       is_system;
        logic [1:0] jmp_op;
        logic [2:0] funct3;
    } ctrl_t;

    // alt = inst[30] where it selects SUB / SRA
    function automatic alu_sel_e alu_op_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// RV32I instruction decoder.
// Ports:
//   inst    in  32  instruction word
//   rs1/rs2/rd out 5 register indices
//   imm     out 32  sign-extended immediate for the instruction's format
//   ctrl    out     decoded control bundle (ctrl_t)
//   illegal out 1   unknown opcode or illegal funct3/funct7 combination
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm            = i_imm;
        illegal        = 1'b0;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.src_b_imm = 1'b0;
        ctrl.reg_write = 1'b0;
        ctrl.is_load   = 1'b0;
        ctrl.is_store  = 1'b0;
        ctrl.is_branch = 1'b0;
        ctrl.is_jalr   = 1'b0;
        ctrl.is_system = 1'b0;
        ctrl.jmp_op    = JMP_SEQ;
        ctrl.funct3    = funct3;
        case (opcode)
            OPC_LUI: begin
                imm            = u_imm;
                ctrl.alu_sel   = ALU_PASS_IMM;
                ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm            = u_imm;
                ctrl.alu_sel   = ALU_PC_IMM;
                ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm            = j_imm;
                ctrl.alu_sel   = ALU_PC_4;
                ctrl.reg_write = 1'b1;
                ctrl.jmp_op    = JMP_JUMP;
            end
            OPC_JALR: begin
                ctrl.alu_sel   = ALU_PC_4;
                ctrl.reg_write = 1'b1;
                ctrl.jmp_op    = JMP_JUMP;
                ctrl.is_jalr   = 1'b1;
                illegal        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm            = b_imm;
                ctrl.is_branch = 1'b1;
                ctrl.jmp_op    = JMP_BRANCH;
                illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                ctrl.is_load   = 1'b1;
                ctrl.reg_write = 1'b1;
                illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm            = s_imm;
                ctrl.is_store  = 1'b1;
                illegal        = (funct3 > F3_SW);
            end
            OPC_OP_IMM: begin
                ctrl.src_b_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                // inst[30] only means SRAI; for ADDI it is an immediate bit
                ctrl.alu_sel   = alu_op_sel(funct3, inst[30] && (funct3 == F3_SR));
                illegal        = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                                 ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_sel   = alu_op_sel(funct3, inst[30]);
                illegal        = ((funct7 != F7_BASE) && (funct7 != F7_ALT)) ||
                                 ((funct7 == F7_ALT) && (funct3 != F3_ADD) && (funct3 != F3_SR));
            end
            OPC_FENCE: ;
            OPC_SYSTEM: ctrl.is_system = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_datapath.sv
// Single-cycle RV32I execute datapath: decode, ALU, branch/jump target,
// load/store formatting and a sticky halt flag.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   inst, pc               instruction and its address
//   rs1_data, rs2_data     register file read data
//   mem_rdata              data-memory word at mem_addr (combinational)
//   rs1, rs2, rd           register indices
//   rd_we, rd_wdata        write-back
//   jmp_op, next_addr, cmp PC control
//   mem_addr, mem_wdata, mem_we  data memory (stores are read-modify-write)
//   fault                  current instruction is illegal/misaligned
//   halted                 sticky, set on fault or ECALL/EBREAK
// Build option: define EXEC_MISALIGN_FAULT_EN to fault on misaligned
// half/word accesses and jump/branch targets with bit1 set.
module rv32i_exec_datapath
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [XLEN-1:0] rd_wdata,
    output logic [1:0]      jmp_op,
    output logic [XLEN-1:0] next_addr,
    output logic            cmp,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            fault,
    output logic            halted
);

    ctrl_t           ctrl;
    logic [31:0]     imm;
    logic            illegal;
    logic [31:0]     op_b;
    logic [31:0]     alu_res;
    logic [31:0]     load_data;
    logic [31:0]     target;
    logic            misalign;
    logic            halted_q, halted_d;

    rv32i_decoder u_dec (
        .inst    (inst),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .imm     (imm),
        .ctrl    (ctrl),
        .illegal (illegal)
    );

    assign op_b     = ctrl.src_b_imm ? imm : rs2_data;
    assign mem_addr = rs1_data + imm;

    // Integer ALU / write-back value selection
    always_comb begin
        alu_res = '0;
        case (ctrl.alu_sel)
            ALU_ADD:      alu_res = rs1_data + op_b;
            ALU_SUB:      alu_res = rs1_data - op_b;
            ALU_SLL:      alu_res = rs1_data << op_b[4:0];
            ALU_SLT:      alu_res = {31'b0, $signed(rs1_data) < $signed(op_b)};
            ALU_SLTU:     alu_res = {31'b0, rs1_data < op_b};
            ALU_XOR:      alu_res = rs1_data ^ op_b;
            ALU_SRL:      alu_res = rs1_data >> op_b[4:0];
            ALU_SRA:      alu_res = $signed(rs1_data) >>> op_b[4:0];
            ALU_OR:       alu_res = rs1_data | op_b;
            ALU_AND:      alu_res = rs1_data & op_b;
            ALU_PASS_IMM: alu_res = imm;
            ALU_PC_IMM:   alu_res = pc + imm;
            ALU_PC_4:     alu_res = pc + 32'd4;
            default:      alu_res = '0;
        endcase
    end

    // Branch comparator; forced low for anything that is not a branch
    always_comb begin
        cmp = 1'b0;
        if (ctrl.is_branch) begin
            case (ctrl.funct3)
                F3_BEQ:  cmp = (rs1_data == rs2_data);
                F3_BNE:  cmp = (rs1_data != rs2_data);
                F3_BLT:  cmp = ($signed(rs1_data) <  $signed(rs2_data));
                F3_BGE:  cmp = ($signed(rs1_data) >= $signed(rs2_data));
                F3_BLTU: cmp = (rs1_data <  rs2_data);
                F3_BGEU: cmp = (rs1_data >= rs2_data);
                default: cmp = 1'b0;
            endcase
        end
    end

    // Jump/branch target: JALR clears bit0, JAL/branch are pc-relative
    always_comb begin
        target = '0;
        if (ctrl.is_jalr)
            target = (rs1_data + imm) & ~32'd1;
        else if (ctrl.jmp_op != JMP_SEQ)
            target = pc + imm;
    end
    assign next_addr = target;

    // Load formatting: little-endian lane select, then sign/zero extend
    always_comb begin
        load_data = mem_rdata;
        case (ctrl.funct3)
            F3_LB, F3_LBU: begin
                case (mem_addr[1:0])
                    2'd0:    load_data = {24'b0, mem_rdata[7:0]};
                    2'd1:    load_data = {24'b0, mem_rdata[15:8]};
                    2'd2:    load_data = {24'b0, mem_rdata[23:16]};
                    default: load_data = {24'b0, mem_rdata[31:24]};
                endcase
                if (ctrl.funct3 == F3_LB)
                    load_data[31:8] = {24{load_data[7]}};
            end
            F3_LH, F3_LHU: begin
                load_data = mem_addr[1] ? {16'b0, mem_rdata[31:16]} : {16'b0, mem_rdata[15:0]};
                if (ctrl.funct3 == F3_LH)
                    load_data[31:16] = {16{load_data[15]}};
            end
            default: load_data = mem_rdata;
        endcase
    end

    // Store formatting: splice rs2 low bits into the current memory word
    always_comb begin
        mem_wdata = mem_rdata;
        case (ctrl.funct3)
            F3_SB: begin
                case (mem_addr[1:0])
                    2'd0:    mem_wdata[7:0]   = rs2_data[7:0];
                    2'd1:    mem_wdata[15:8]  = rs2_data[7:0];
                    2'd2:    mem_wdata[23:16] = rs2_data[7:0];
                    default: mem_wdata[31:24] = rs2_data[7:0];
                endcase
            end
            F3_SH: begin
                if (mem_addr[1])
                    mem_wdata[31:16] = rs2_data[15:0];
                else
                    mem_wdata[15:0]  = rs2_data[15:0];
            end
            default: mem_wdata = rs2_data;
        endcase
    end

`ifdef EXEC_MISALIGN_FAULT_EN
    always_comb begin
        misalign = 1'b0;
        if (ctrl.is_load || ctrl.is_store) begin
            // funct3[1:0]: 01 = half, 10 = word (both loads and stores)
            case (ctrl.funct3[1:0])
                2'b01:   misalign = mem_addr[0];
                2'b10:   misalign = |mem_addr[1:0];
                default: misalign = 1'b0;
            endcase
        end
        if ((ctrl.jmp_op != JMP_SEQ) && target[1])
            misalign = 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

    assign fault    = illegal || (ctrl.jmp_op == JMP_RSVD) || misalign;
    assign rd_wdata = ctrl.is_load ? load_data : alu_res;
    assign rd_we    = ctrl.reg_write && (rd != 5'd0) && !fault && !halted_q;
    assign mem_we   = ctrl.is_store && !fault && !halted_q;
    assign jmp_op   = halted_q ? JMP_SEQ : ctrl.jmp_op;

    always_comb begin
        halted_d = halted_q || fault || ctrl.is_system;
    end

    always_ff @(posedge clk) begin
        if (rst)
            halted_q <= 1'b0;
        else
            halted_q <= halted_d;
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
module tb_rv32i_exec_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, pc, rs1_data, rs2_data, mem_rdata;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, cmp, mem_we, fault, halted;
    logic [31:0] rd_wdata, next_addr, mem_addr, mem_wdata;
    logic [1:0]  jmp_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_exec_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .mem_rdata (mem_rdata),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rd_we     (rd_we),
        .rd_wdata  (rd_wdata),
        .jmp_op    (jmp_op),
        .next_addr (next_addr),
        .cmp       (cmp),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .fault     (fault),
        .halted    (halted)
    );

    typedef struct {
        string       nm;
        logic [4:0]  rd, rs1, rs2;
        logic        rd_we;
        logic [31:0] wd;
        logic [1:0]  jop;
        logic [31:0] nxt;
        logic        cmp;
        logic        mwe;
        logic [31:0] mwd, maddr;
        logic        flt, hlt;
        bit          chk_rs, chk_wd, chk_mwd, chk_ma, chk_ctl;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, JALR = 7'b1100111,
                           JAL = 7'b1101111;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, s1,
                                          input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {f7, s2, s1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2, s1,
                                          input logic [2:0] f3);
        return {im[11:5], s2, s1, f3, im[4:0], ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2, s1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], BR};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, JAL};
    endfunction

    function automatic exp_t base(input string nm);
        exp_t x;
        x.nm = nm; x.rd = '0; x.rs1 = '0; x.rs2 = '0; x.rd_we = 1'b0; x.wd = '0;
        x.jop = 2'd0; x.nxt = '0; x.cmp = 1'b0; x.mwe = 1'b0; x.mwd = '0; x.maddr = '0;
        x.flt = 1'b0; x.hlt = 1'b0;
        x.chk_rs = 1'b0; x.chk_wd = 1'b0; x.chk_mwd = 1'b0; x.chk_ma = 1'b0; x.chk_ctl = 1'b1;
        return x;
    endfunction

    task automatic ck(input string nm, input string f, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, want);
        end
    endtask

    // Apply one vector just after a rising edge and queue its expectation
    task automatic go(input logic [31:0] i, p, a, b, m);
        @(posedge clk); #1;
        inst = i; pc = p; rs1_data = a; rs2_data = b; mem_rdata = m;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Monitor: compare on the falling edge, away from the halt register update
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            ck(x.nm, "rd", {27'b0, rd}, {27'b0, x.rd});
            ck(x.nm, "rd_we", {31'b0, rd_we}, {31'b0, x.rd_we});
            ck(x.nm, "mem_we", {31'b0, mem_we}, {31'b0, x.mwe});
            ck(x.nm, "fault", {31'b0, fault}, {31'b0, x.flt});
            ck(x.nm, "halted", {31'b0, halted}, {31'b0, x.hlt});
            if (x.chk_rs) begin
                ck(x.nm, "rs1", {27'b0, rs1}, {27'b0, x.rs1});
                ck(x.nm, "rs2", {27'b0, rs2}, {27'b0, x.rs2});
            end
            if (x.chk_wd)  ck(x.nm, "rd_wdata", rd_wdata, x.wd);
            if (x.chk_mwd) ck(x.nm, "mem_wdata", mem_wdata, x.mwd);
            if (x.chk_ma)  ck(x.nm, "mem_addr", mem_addr, x.maddr);
            if (x.chk_ctl) begin
                ck(x.nm, "jmp_op", {30'b0, jmp_op}, {30'b0, x.jop});
                ck(x.nm, "next_addr", next_addr, x.nxt);
                ck(x.nm, "cmp", {31'b0, cmp}, {31'b0, x.cmp});
            end
        end
    end

    initial begin
        rst = 1'b1; inst = 32'h13; pc = '0; rs1_data = '0; rs2_data = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        e = base("nop_rst"); e.chk_wd = 1; go(32'h00000013, 0, 0, 0, 0);

        // ALU
        e = base("addi"); e.rd = 1; e.rd_we = 1; e.wd = 32'hFFFFFFFB; e.chk_wd = 1;
        go(32'hFFB00093, 0, 0, 0, 0);
        e = base("sub"); e.rd = 3; e.rs1 = 1; e.rs2 = 2; e.chk_rs = 1; e.rd_we = 1;
        e.wd = 32'hFFFFFFFE; e.chk_wd = 1;
        go(enc_r(7'h20, 2, 1, 3'b000, 3, OP), 0, 3, 5, 0);
        e = base("sra"); e.rd = 4; e.rd_we = 1; e.wd = 32'hF8000000; e.chk_wd = 1;
        go(enc_r(7'h20, 2, 1, 3'b101, 4, OP), 0, 32'h80000000, 4, 0);
        e = base("sltu"); e.rd = 5; e.rd_we = 1; e.wd = 32'h1; e.chk_wd = 1;
        go(enc_r(7'h00, 2, 1, 3'b011, 5, OP), 0, 1, 32'hFFFFFFFF, 0);
        e = base("srai"); e.rd = 6; e.rd_we = 1; e.wd = 32'hF8000000; e.chk_wd = 1;
        go(enc_i(12'h404, 1, 3'b101, 6, OPI), 0, 32'h80000000, 0, 0);
        e = base("lui"); e.rd = 7; e.rd_we = 1; e.wd = 32'h12345000; e.chk_wd = 1;
        go({20'h12345, 5'd7, 7'b0110111}, 0, 0, 0, 0);
        e = base("auipc"); e.rd = 8; e.rd_we = 1; e.wd = 32'h00001100; e.chk_wd = 1;
        go({20'h00001, 5'd8, 7'b0010111}, 32'h100, 0, 0, 0);

        // branches: imm -8 from pc 0x100; rd field holds imm bits -> 25
        e = base("blt"); e.rd = 25; e.jop = 2; e.cmp = 1; e.nxt = 32'hF8;
        go(enc_b(13'h1FF8, 2, 1, 3'b100), 32'h100, 32'hFFFFFFFF, 0, 0);
        e = base("bgeu"); e.rd = 25; e.jop = 2; e.cmp = 1; e.nxt = 32'hF8;
        go(enc_b(13'h1FF8, 2, 1, 3'b111), 32'h100, 32'hFFFFFFFF, 0, 0);
        e = base("beq"); e.rd = 25; e.jop = 2; e.cmp = 0; e.nxt = 32'hF8;
        go(enc_b(13'h1FF8, 2, 1, 3'b000), 32'h100, 32'hFFFFFFFF, 0, 0);

        // loads / stores
        e = base("lb"); e.rd = 9; e.rd_we = 1; e.wd = 32'hFFFFFF80; e.chk_wd = 1;
        e.maddr = 32'h13; e.chk_ma = 1;
        go(enc_i(12'h003, 1, 3'b000, 9, LD), 0, 32'h10, 0, 32'h80FF1234);
        e = base("lhu"); e.rd = 10; e.rd_we = 1; e.wd = 32'h000080FF; e.chk_wd = 1;
        e.maddr = 32'h12; e.chk_ma = 1;
        go(enc_i(12'h002, 1, 3'b101, 10, LD), 0, 32'h10, 0, 32'h80FF1234);
        e = base("sb"); e.rd = 1; e.mwe = 1; e.mwd = 32'h80FFAB34; e.chk_mwd = 1;
        e.maddr = 32'h11; e.chk_ma = 1;
        go(enc_s(12'h001, 2, 1, 3'b000), 0, 32'h10, 32'hAB, 32'h80FF1234);
        e = base("sw"); e.rd = 0; e.mwe = 1; e.mwd = 32'hDEADBEEF; e.chk_mwd = 1;
        e.maddr = 32'h20; e.chk_ma = 1;
        go(enc_s(12'h000, 2, 1, 3'b010), 0, 32'h20, 32'hDEADBEEF, 32'h11111111);

        // jumps
        e = base("jal"); e.rd = 1; e.rd_we = 1; e.wd = 32'h44; e.chk_wd = 1; e.jop = 1; e.nxt = 32'h50;
        go(enc_j(21'h10, 1), 32'h40, 0, 0, 0);
        e = base("jalr"); e.rd = 1; e.rd_we = 1; e.wd = 32'h44; e.chk_wd = 1; e.jop = 1; e.nxt = 32'h200;
        go(enc_i(12'h000, 1, 3'b000, 1, JALR), 32'h40, 32'h201, 0, 0);

        // word load at addr 0x2
        e = base("lw_mis"); e.rd = 11; e.maddr = 32'h2; e.chk_ma = 1;
`ifdef EXEC_MISALIGN_FAULT_EN
        e.flt = 1;
`else
        e.rd_we = 1; e.wd = 32'h80FF1234; e.chk_wd = 1;
`endif
        go(enc_i(12'h002, 1, 3'b010, 11, LD), 0, 0, 0, 32'h80FF1234);
        do_reset();

        // illegal funct7 on SLL, then halted observed
        e = base("sll_f7"); e.rd = 12; e.flt = 1;
        go(enc_r(7'h20, 2, 1, 3'b001, 12, OP), 0, 1, 1, 0);
        e = base("post_f7"); e.hlt = 1; go(32'h00000013, 0, 0, 0, 0);
        do_reset();

        // unknown opcode
        e = base("op7f"); e.flt = 1; go(32'h0000007F, 0, 0, 0, 0);
        e = base("post_7f"); e.rd = 1; e.hlt = 1; go(32'hFFB00093, 0, 0, 0, 0);
        do_reset();
        e = base("after_rst"); e.rd = 1; e.rd_we = 1; e.wd = 32'hFFFFFFFB; e.chk_wd = 1;
        go(32'hFFB00093, 0, 0, 0, 0);

        // ECALL: halted next edge, sticky, gates jumps and write-back
        e = base("ecall"); go(32'h00000073, 0, 0, 0, 0);
        e = base("halt1"); e.hlt = 1; go(32'h00000013, 0, 0, 0, 0);
        e = base("halt_jal"); e.rd = 1; e.hlt = 1; e.jop = 0; e.nxt = 32'h50;
        go(enc_j(21'h10, 1), 32'h40, 0, 0, 0);
        e = base("halt_sw"); e.hlt = 1; e.mwe = 0;
        go(enc_s(12'h000, 2, 1, 3'b010), 0, 32'h20, 32'h5, 0);
        do_reset();
        e = base("rst_clr"); e.rd = 1; e.rd_we = 1; e.wd = 32'hFFFFFFFB; e.chk_wd = 1;
        go(32'hFFB00093, 0, 0, 0, 0);

        // drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
